// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a latched block of N_WORDS words as 8N1 UART frames.
// Word 0 goes first; within a word the most significant byte goes first.
// Bit timing follows the external 1-clk baud_tick strobe; tx comes from a flop.
module uart_word_tx #(
  parameter int N_WORDS = 4,
  parameter int WORD_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        baud_tick,
  input  logic                        send,
  input  logic [N_WORDS*WORD_W-1:0]   words,
  output logic                        tx,
  output logic                        tx_ready,
  output logic                        done
);

  localparam int TW  = N_WORDS * WORD_W;
  localparam int B   = TW / 8;
  localparam int BPW = WORD_W / 8;
  localparam int BW  = $clog2(B) + 1;

  if ((WORD_W % 8) != 0 || N_WORDS < 1) begin : g_param_chk
    $error("uart_word_tx: WORD_W must be a multiple of 8 and N_WORDS >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   wbuf_q, wbuf_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [BW-1:0]   byte_idx_q, byte_idx_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  logic [BW-1:0]   ld_idx;
  logic [7:0]      ld_byte;

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign done     = done_q;

  // Byte to load into the shift register: the current byte when leaving ALIGN,
  // the following byte when chaining out of STOP straight into the next START.
  always_comb begin
    ld_idx  = (state_q == S_STOP) ? byte_idx_q + BW'(1) : byte_idx_q;
    ld_byte = '0;
    for (int unsigned k = 0; k < B; k++) begin
      if (ld_idx == BW'(k)) begin
        ld_byte = wbuf_q[(k / BPW) * WORD_W + WORD_W - 8 - (k % BPW) * 8 +: 8];
      end
    end
  end

  // Next-state and registered-output logic for the frame sequencer.
  // The shift register is loaded on entry to START rather than inside it, so the
  // first data bit can be presented on the very tick that ends the start bit.
  always_comb begin
    state_d    = state_q;
    wbuf_d     = wbuf_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (send && ready_q) begin
          wbuf_d     = words;
          byte_idx_d = '0;
          ready_d    = 1'b0;
          state_d    = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          shift_d = ld_byte;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d     = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = '0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bitcnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d     = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (byte_idx_q == BW'(B - 1)) begin
            byte_idx_d = '0;
            ready_d    = 1'b1;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
            tx_d       = 1'b0;
            shift_d    = ld_byte;
            state_d    = S_START;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  // State registers; reset returns the line to idle-high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wbuf_q     <= '0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      byte_idx_q <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wbuf_q     <= wbuf_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx: one 1-word and one 4-word instance sharing clock,
// reset and baud tick. The line is sampled on every tick edge and decoded by a
// UART frame model; expected bytes come from tables or a word-stream model.
module tb_uart_word_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        send1, send4;
  logic [15:0] words1;
  logic [63:0] words4;
  logic        tx1, rdy1, done1;
  logic        tx4, rdy4, done4;

  uart_word_tx #(.N_WORDS(1), .WORD_W(16)) dut1 (
    .clk(clk), .reset(reset), .baud_tick(tick), .send(send1), .words(words1),
    .tx(tx1), .tx_ready(rdy1), .done(done1)
  );

  uart_word_tx #(.N_WORDS(4), .WORD_W(16)) dut4 (
    .clk(clk), .reset(reset), .baud_tick(tick), .send(send4), .words(words4),
    .tx(tx4), .tx_ready(rdy4), .done(done4)
  );

  always #5 clk = ~clk;

  // Observed instance select.
  logic sel;
  logic tx_s, ready_s, done_s;
  assign tx_s    = sel ? tx4   : tx1;
  assign ready_s = sel ? rdy4  : rdy1;
  assign done_s  = sel ? done4 : done1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Baud tick source: 0 = off, 1 = tied high, 2 = fixed period, 3 = random 1..20.
  int tmode = 0;
  int tper  = 16;
  int tcnt  = 0;
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tmode == 0) tick = 1'b0;
      else if (tmode == 1) tick = 1'b1;
      else if (tcnt + 1 >= tper) begin
        tick = 1'b1;
        tcnt = 0;
        if (tmode == 3) tper = int'($urandom_range(1, 20));
      end else begin
        tick = 1'b0;
        tcnt++;
      end
    end
  end

  // Line monitor: records tx after every tick edge while capturing.
  logic bitq[$];
  int   donecnt = 0, rdyviol = 0, idleviol = 0, chgviol = 0;
  bit   cap = 0, mon_chg = 0, scramble = 0;
  logic prev_tx = 1'b1;
  initial begin
    logic t;
    forever begin
      @(posedge clk);
      t = tick;
      #1;
      if (cap) begin
        if (t) bitq.push_back(tx_s);
        if (done_s) donecnt++;
        if (ready_s && !done_s) rdyviol++;
      end
      if (ready_s && !tx_s) idleviol++;
      if (mon_chg && !t && tx_s !== prev_tx) chgviol++;
      prev_tx = tx_s;
    end
  end

  task automatic set_send(input logic v);
    if (sel) send4 = v;
    else send1 = v;
  endtask

  // Reference model: words streamed in index order, each word big-endian.
  function automatic logic [63:0] model_bytes(input logic [63:0] w);
    logic [63:0] r = '0;
    for (int i = 0; i < 4; i++) r = {r[47:0], w[16*i +: 16]};
    return r;
  endfunction

  // UART frame decoder over the captured tick samples.
  task automatic decode(input int nb, output logic [63:0] bytes, output logic frame_ok);
    bytes    = '0;
    frame_ok = 1'b1;
    if (bitq.size() < 10 * nb) begin
      frame_ok = 1'b0;
      return;
    end
    for (int k = 0; k < nb; k++) begin
      logic [7:0] b;
      if (bitq[10*k] !== 1'b0 || bitq[10*k+9] !== 1'b1) frame_ok = 1'b0;
      for (int j = 0; j < 8; j++) b[j] = bitq[10*k+1+j];
      bytes = {bytes[55:0], b};
    end
  endtask

  function automatic logic [63:0] first_bits(input int n);
    logic [63:0] r = '0;
    if (bitq.size() < n) return 'x;
    for (int i = 0; i < n; i++) r = {r[62:0], bitq[i]};
    return r;
  endfunction

  task automatic accept_start(input bit hold);
    bitq.delete();
    donecnt = 0;
    rdyviol = 0;
    @(negedge clk);
    set_send(1'b1);
    @(posedge clk);
    #2;
    cap = 1;
    if (!hold) set_send(1'b0);
    chk("ready_drop", 64'(ready_s), 64'(0));
  endtask

  task automatic wait_done(output int clks, output bit ok);
    clks = 0;
    ok   = 0;
    while (clks < 5000) begin
      @(posedge clk);
      #2;
      clks++;
      if (scramble) words4 = {$urandom, $urandom};
      if (done_s) begin
        ok = 1;
        break;
      end
    end
    cap = 0;
  endtask

  task automatic full_transfer(input int nb, input bit hold, output int clks);
    bit ok;
    accept_start(hold);
    wait_done(clks, ok);
    chk("done_seen", 64'(ok), 64'(1));
    chk("tick_latency", 64'(bitq.size()), 64'(10 * nb + 1));
    chk("done_pulses", 64'(donecnt), 64'(1));
    chk("ready_low_during", 64'(rdyviol), 64'(0));
    chk("ready_at_done", 64'(ready_s), 64'(1));
    if (!hold) begin
      @(posedge clk);
      #2;
      chk("done_clear", 64'(done_s), 64'(0));
    end
  endtask

  typedef struct {
    logic [63:0] words;
    int          period;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[3];

  initial begin
    int          clks, n, dn;
    logic [63:0] bytes, latched, dw, w1, w2;
    logic        fok;

    vecs[0] = '{64'hD1D2_C1C2_B1B2_A1A2, 16, 64'hA1A2_B1B2_C1C2_D1D2};
    vecs[1] = '{64'h0000_FFFF_8001_1234, 3,  64'h1234_8001_FFFF_0000};
    vecs[2] = '{64'h55AA_0F0F_F0F0_00FF, 1,  64'h00FF_F0F0_0F0F_55AA};

    reset = 1'b1; send1 = 1'b0; send4 = 1'b0; words1 = '0; words4 = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx1", 64'(tx1), 64'(1));
    chk("rst_ready1", 64'(rdy1), 64'(1));
    chk("rst_done1", 64'(done1), 64'(0));
    chk("rst_tx4", 64'(tx4), 64'(1));
    chk("rst_ready4", 64'(rdy4), 64'(1));
    chk("rst_done4", 64'(done4), 64'(0));
    @(negedge clk);
    reset   = 1'b0;
    mon_chg = 1;

    // Single word 0x1234, tick every 16 clocks.
    sel = 1'b0; words1 = 16'h1234; tper = 16; tmode = 2;
    full_transfer(2, 0, clks);
    chk("t1_bits", first_bits(20), 64'(20'b0_01001000_1_0_00101100_1));

    // Tick tied high, 0x00FF: one bit per clock, done on clock 21.
    words1 = 16'h00FF; tmode = 1;
    full_transfer(2, 0, clks);
    chk("t5_clks", 64'(clks), 64'(21));
    chk("t5_bits", first_bits(20), 64'(20'b0_00000000_1_0_11111111_1));

    // Table-driven four-word transfers.
    sel = 1'b1; tmode = 2;
    for (int i = 0; i < 3; i++) begin
      words4 = vecs[i].words;
      tper   = vecs[i].period;
      full_transfer(8, 0, clks);
      decode(8, bytes, fok);
      chk("vec_frame", 64'(fok), 64'(1));
      chk("vec_bytes", bytes, vecs[i].exp);
    end

    // send held high with words changing mid-transfer; re-accepted in the done cycle.
    w1 = 64'h0102_0304_0506_0708; w2 = 64'hCAFE_BEEF_DEAD_F00D;
    tper = 5; words4 = w1; scramble = 1;
    full_transfer(8, 1, clks);
    scramble = 0;
    words4   = w2;
    decode(8, bytes, fok);
    chk("t3_first_frame", 64'(fok), 64'(1));
    chk("t3_first_bytes", bytes, model_bytes(w1));
    full_transfer(8, 0, clks);
    decode(8, bytes, fok);
    chk("t3_second_frame", 64'(fok), 64'(1));
    chk("t3_second_bytes", bytes, model_bytes(w2));

    // Reset during data bit 3 of byte 1.
    tper = 4; words4 = vecs[0].words;
    accept_start(0);
    n = 0;
    while (bitq.size() < 15 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("t4_reach_bit", 64'(bitq.size()), 64'(15));
    chk("t4_bit3_low", 64'(bitq.size() >= 15 ? bitq[14] : 1'bx), 64'(0));
    mon_chg = 0;
    #1 reset = 1'b1;
    #1;
    chk("t4_tx_high", 64'(tx4), 64'(1));
    chk("t4_ready", 64'(rdy4), 64'(1));
    chk("t4_done_low", 64'(done4), 64'(0));
    cap = 0;
    dn  = 0;
    repeat (3) begin
      @(posedge clk);
      #2;
      if (done4) dn++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #2;
      if (done4 || !tx4) dn++;
    end
    chk("t4_quiet_after", 64'(dn), 64'(0));
    mon_chg = 1;
    words4 = 64'h0123_4567_89AB_CDEF;
    full_transfer(8, 0, clks);
    decode(8, bytes, fok);
    chk("t4_new_frame", 64'(fok), 64'(1));
    chk("t4_new_bytes", bytes, model_bytes(64'h0123_4567_89AB_CDEF));

    // Random words with random tick spacing; decode back to words.
    tmode = 3;
    for (int r = 0; r < 6; r++) begin
      words4  = {$urandom, $urandom};
      latched = words4;
      full_transfer(8, 0, clks);
      decode(8, bytes, fok);
      chk("t6_frame", 64'(fok), 64'(1));
      dw = '0;
      for (int i = 0; i < 4; i++) dw[16*i +: 16] = bytes[63-16*i -: 16];
      chk("t6_words", dw, latched);
    end

    chk("tx_low_while_ready", 64'(idleviol), 64'(0));
    chk("tx_change_without_tick", 64'(chgviol), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
